// File: rtl/io_uart_pkg.sv
// Shared definitions for the io_uart serial I/O unit: register offsets, STATUS bit positions
// and FSM state types. Optional 8E1 framing is enabled by defining IO_UART_PARITY_EN.
package io_uart_pkg;

  localparam logic OFS_DATA   = 1'b0;
  localparam logic OFS_STATUS = 1'b1;

  localparam int unsigned ST_RX_AVAIL = 0;
  localparam int unsigned ST_TX_SPACE = 1;
  localparam int unsigned ST_TX_BUSY  = 2;
  localparam int unsigned ST_RX_OVR   = 3;
  localparam int unsigned ST_FRM_ERR  = 4;
  localparam int unsigned ST_PAR_ERR  = 5;
  localparam int unsigned ST_TX_OVF   = 6;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef IO_UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef IO_UART_PARITY_EN
    RxParity,
`endif
    RxStop
  } rx_state_e;

endpackage

// File: rtl/io_uart_fifo.sv
// Byte FIFO with an extra pointer bit to tell full from empty. A push on a full FIFO is
// accepted only when a pop happens in the same cycle. Used by io_uart (IO_UART_PARITY_EN-agnostic).
module io_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART on the TinyComp I/O bus: DATA/STATUS registers, TX and RX FSMs with baud
// counters, and two byte FIFOs. Define IO_UART_PARITY_EN for 8E1 frames (default 8N1).
module io_uart
  import io_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0010
) (
  input  logic        Ph0,
  input  logic        Reset,
  input  logic [31:0] IOaddr,
  input  logic [31:0] OutData,
  input  logic        OutStrobe,
  input  logic        InStrobe,
  output logic [31:0] InData,
  output logic        InRdy,
  input  logic        RxD,
  output logic        TxD
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CntOne   = 1;

  // Bus decode
  logic sel, ofs, tx_wr, rx_rd, st_rd;
  logic unused_outdata;

  assign sel   = (IOaddr[31:1] == BASE_ADDR[31:1]);
  assign ofs   = IOaddr[0];
  assign tx_wr = sel & OutStrobe & (ofs == OFS_DATA);
  assign rx_rd = sel & InStrobe & (ofs == OFS_DATA);
  assign st_rd = sel & InStrobe & (ofs == OFS_STATUS);
  assign unused_outdata = ^OutData[31:8];

  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;
  logic [7:0] rx_head;

  io_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (Ph0),
    .reset_i (Reset),
    .push_i  (tx_wr),
    .wdata_i (OutData[7:0]),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  // TX FSM
  tx_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_done, tx_load;
`ifdef IO_UART_PARITY_EN
  logic        tx_par_q, tx_par_d;
`endif

  assign tx_done = (tx_cnt_q == BitLast);
  assign tx_pop  = tx_load;
  assign TxD     = txd_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_done ? '0 : tx_cnt_q + CntOne;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
`ifdef IO_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        tx_load  = ~tx_empty;
      end
      TxStart: begin
        if (tx_done) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_done) begin
          if (tx_bit_q == 3'd7) begin
`ifdef IO_UART_PARITY_EN
            tx_state_d = TxParity;
            txd_d      = tx_par_q;
`else
            tx_state_d = TxStop;
            txd_d      = 1'b1;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
`ifdef IO_UART_PARITY_EN
      TxParity: begin
        if (tx_done) begin
          tx_state_d = TxStop;
          txd_d      = 1'b1;
        end
      end
`endif
      TxStop: begin
        if (tx_done) begin
          tx_state_d = TxIdle;
          tx_load    = ~tx_empty;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    // Loading from IDLE or straight out of STOP gives back-to-back frames
    if (tx_load) begin
      tx_state_d = TxStart;
      tx_cnt_d   = '0;
      tx_shift_d = tx_head;
      txd_d      = 1'b0;
`ifdef IO_UART_PARITY_EN
      tx_par_d   = ^tx_head;
`endif
    end
  end

  always_ff @(posedge Ph0) begin
    if (Reset) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

`ifdef IO_UART_PARITY_EN
  always_ff @(posedge Ph0) begin
    if (Reset) tx_par_q <= 1'b0;
    else       tx_par_q <= tx_par_d;
  end
`endif

  // RX synchroniser and FSM
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  rx_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done, frm_ev;
`ifdef IO_UART_PARITY_EN
  logic        rx_par_bad_q, rx_par_bad_d, par_ev;
`endif

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_done = (rx_cnt_q == BitLast);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_done ? '0 : rx_cnt_q + CntOne;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frm_ev     = 1'b0;
`ifdef IO_UART_PARITY_EN
    rx_par_bad_d = rx_par_bad_q;
    par_ev       = 1'b0;
`endif
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
`ifdef IO_UART_PARITY_EN
          rx_par_bad_d = 1'b0;
`endif
        end
      end
      RxData: begin
        if (rx_done) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
`ifdef IO_UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end
        end
      end
`ifdef IO_UART_PARITY_EN
      RxParity: begin
        if (rx_done) begin
          rx_state_d = RxStop;
          if (rx_s2_q != ^rx_shift_q) begin
            rx_par_bad_d = 1'b1;
            par_ev       = 1'b1;
          end
        end
      end
`endif
      RxStop: begin
        if (rx_done) begin
          rx_state_d = RxIdle;
          if (!rx_s2_q) begin
            frm_ev = 1'b1;
          end else begin
`ifdef IO_UART_PARITY_EN
            rx_push = ~rx_par_bad_q;
`else
            rx_push = 1'b1;
`endif
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge Ph0) begin
    if (Reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= RxD;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

`ifdef IO_UART_PARITY_EN
  always_ff @(posedge Ph0) begin
    if (Reset) rx_par_bad_q <= 1'b0;
    else       rx_par_bad_q <= rx_par_bad_d;
  end
`endif

  io_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (Ph0),
    .reset_i (Reset),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (rx_rd),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  // Sticky error bits: a read of STATUS clears them, but a same-cycle event wins
  logic ovr_q, ovr_d, frm_q, frm_d, txovf_q, txovf_d, par_err;
  logic ovr_ev, txovf_ev;

  assign ovr_ev   = rx_push & rx_full & ~rx_rd;
  assign txovf_ev = tx_wr & tx_full & ~tx_pop;
  assign ovr_d    = (ovr_q & ~st_rd) | ovr_ev;
  assign frm_d    = (frm_q & ~st_rd) | frm_ev;
  assign txovf_d  = (txovf_q & ~st_rd) | txovf_ev;

  always_ff @(posedge Ph0) begin
    if (Reset) begin
      ovr_q   <= 1'b0;
      frm_q   <= 1'b0;
      txovf_q <= 1'b0;
    end else begin
      ovr_q   <= ovr_d;
      frm_q   <= frm_d;
      txovf_q <= txovf_d;
    end
  end

`ifdef IO_UART_PARITY_EN
  logic par_q;
  always_ff @(posedge Ph0) begin
    if (Reset) par_q <= 1'b0;
    else       par_q <= (par_q & ~st_rd) | par_ev;
  end
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

  logic [31:0] status;

  always_comb begin
    status              = '0;
    status[ST_RX_AVAIL] = ~rx_empty;
    status[ST_TX_SPACE] = ~tx_full;
    status[ST_TX_BUSY]  = ~tx_empty | (tx_state_q != TxIdle);
    status[ST_RX_OVR]   = ovr_q;
    status[ST_FRM_ERR]  = frm_q;
    status[ST_PAR_ERR]  = par_err;
    status[ST_TX_OVF]   = txovf_q;
  end

  always_comb begin
    InData = '0;
    InRdy  = 1'b0;
    if (sel) begin
      if (ofs == OFS_DATA) begin
        InRdy = ~rx_empty;
        if (!rx_empty) InData = {24'b0, rx_head};
      end else begin
        InData = status;
        InRdy  = ~tx_full;
      end
    end
  end

endmodule
